// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter, up to STEP bit positions per clock, start/busy/done handshake
// Optional rotate mode under macro SHIFT_ROTATE_EN (adds the rot port).
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             arith,
`ifdef SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] B
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d, b_q;
    logic [SHW-1:0]   cnt_q, cnt_d, k;
    logic             dir_q, arith_q, busy_q, done_q;
`ifdef SHIFT_ROTATE_EN
    logic             rot_q;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
`endif

    // k never exceeds the remaining count, so cnt reaches exactly zero without wrapping
    always_comb begin
        k     = (cnt_q < STEP_W) ? cnt_q : STEP_W;
        cnt_d = cnt_q - k;
        if (!dir_q)
            acc_d = acc_q << k;
        else if (arith_q)
            acc_d = $unsigned($signed(acc_q) >>> k);
        else
            acc_d = acc_q >> k;
`ifdef SHIFT_ROTATE_EN
        // Shifting a doubled copy gives the rotated word in one half
        dbl_l = {acc_q, acc_q} << k;
        dbl_r = {acc_q, acc_q} >> k;
        if (rot_q)
            acc_d = dir_q ? dbl_r[WIDTH-1:0] : dbl_l[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            b_q     <= '0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= A;
                        cnt_q   <= shamt;
                        dir_q   <= dir;
                        arith_q <= arith;
`ifdef SHIFT_ROTATE_EN
                        rot_q   <= rot;
`endif
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                    end else begin
                        b_q     <= acc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign B    = b_q;

endmodule
